// File: rtl/noc_ctrl_pkg.sv
// Shared definitions for the NoC control slice.
//   - Mesh/hierarchy dimensions and the resulting number of node activity lines.
//   - tik_state_t: the timestep scheduler's state type.
package noc_ctrl_pkg;

  localparam int unsigned NX  = 2;
  localparam int unsigned NY  = 2;
  localparam int unsigned NR2 = 6;
  localparam int unsigned NR1 = 6;

  localparam int unsigned NACT_TOTAL = NX * NY * NR2 * NR1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    TIK   = 2'd3
  } tik_state_t;

endpackage

// File: rtl/noc_act_mon.sv
// Network activity monitor.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          restart the quiet window (scheduler entering DRAIN)
//   flit_wr_mon  per-node flit write taps
//   node_busy    per-node busy flags
//   act_q        registered OR of all activity lines
//   quiet        QUIET consecutive idle cycles seen on act_q
module noc_act_mon #(
  parameter int unsigned NACT  = 144,
  parameter int unsigned QUIET = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [NACT-1:0] flit_wr_mon,
  input  logic [NACT-1:0] node_busy,
  output logic            act_q,
  output logic            quiet
);

  localparam int unsigned QW = (QUIET > 1) ? $clog2(QUIET) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QUIET - 1);

  logic [QW-1:0] quiet_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= 1'b0;
      quiet_cnt <= '0;
    end else begin
      act_q <= (|flit_wr_mon) | (|node_busy);
      if (clr || act_q) begin
        quiet_cnt <= '0;
      end else if (quiet_cnt != QMAX) begin
        quiet_cnt <= quiet_cnt + QW'(1);
      end
    end
  end

  // The current idle cycle completes the window once QUIET-1 idle cycles precede it.
  assign quiet = (quiet_cnt == QMAX) && !act_q;

endmodule

// File: rtl/noc_tik_sched.sv
// Timestep scheduler: issues the global tik once the minimum period has
// elapsed and the network has drained, or forces it on drain timeout.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start, stop   run control pulses
//   cfg_period    minimum RUN cycles per timestep (0 acts as 1)
//   cfg_timeout   DRAIN cycle limit before a forced tik (0 = unlimited)
//   cfg_steps     timesteps per run (0 = free-running)
//   flit_wr_mon   node flit write taps
//   node_busy     node busy flags
//   tik           registered 1-cycle global tik
//   ts_cnt        timesteps completed in this run
//   running       high outside IDLE
//   done          1-cycle pulse on return to IDLE
//   timeout_err   sticky: a forced tik occurred this run
module noc_tik_sched
  import noc_ctrl_pkg::*;
#(
  parameter int unsigned NACT  = NACT_TOTAL,
  parameter int unsigned CW    = 16,
  parameter int unsigned QUIET = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [CW-1:0]   cfg_period,
  input  logic [CW-1:0]   cfg_timeout,
  input  logic [CW-1:0]   cfg_steps,
  input  logic [NACT-1:0] flit_wr_mon,
  input  logic [NACT-1:0] node_busy,
  output logic            tik,
  output logic [CW-1:0]   ts_cnt,
  output logic            running,
  output logic            done,
  output logic            timeout_err
);

  tik_state_t    state, state_nx;
  logic [CW-1:0] period_q, timeout_q, steps_q;
  logic [CW-1:0] per_cnt, to_cnt;
  logic [CW-1:0] per_last;
  logic          stop_pend;
  logic          act_q, quiet;
  logic          run_end, to_hit, last_step;

  assign per_last  = (period_q == '0) ? '0 : period_q - CW'(1);
  assign run_end   = (state == RUN) && (per_cnt == per_last);
  assign to_hit    = (timeout_q != '0) && (to_cnt == timeout_q - CW'(1));
  assign last_step = stop_pend || ((steps_q != '0) && (ts_cnt + CW'(1) == steps_q));

  noc_act_mon #(
    .NACT  (NACT),
    .QUIET (QUIET)
  ) u_act_mon (
    .clk         (clk),
    .rst         (rst),
    .clr         (run_end),
    .flit_wr_mon (flit_wr_mon),
    .node_busy   (node_busy),
    .act_q       (act_q),
    .quiet       (quiet)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (run_end) state_nx = DRAIN;
      DRAIN:   if (quiet || to_hit) state_nx = TIK;
      TIK:     state_nx = last_step ? IDLE : RUN;
      default: state_nx = IDLE;
    endcase
  end

  // tik/running/done are decoded from the next state so they come straight
  // out of flops aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tik         <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      ts_cnt      <= '0;
      timeout_err <= 1'b0;
      period_q    <= '0;
      timeout_q   <= '0;
      steps_q     <= '0;
      per_cnt     <= '0;
      to_cnt      <= '0;
      stop_pend   <= 1'b0;
    end else begin
      state   <= state_nx;
      tik     <= (state_nx == TIK);
      running <= (state_nx != IDLE);
      done    <= (state == TIK) && (state_nx == IDLE);

      unique case (state)
        IDLE: begin
          if (start) begin
            period_q    <= cfg_period;
            timeout_q   <= cfg_timeout;
            steps_q     <= cfg_steps;
            ts_cnt      <= '0;
            timeout_err <= 1'b0;
            stop_pend   <= stop;
            per_cnt     <= '0;
          end
        end
        RUN: begin
          per_cnt <= per_cnt + CW'(1);
          to_cnt  <= '0;
        end
        DRAIN: begin
          to_cnt <= to_cnt + CW'(1);
          // A drain completing in the same cycle as the timeout is not an error.
          if (!quiet && to_hit) timeout_err <= 1'b1;
        end
        TIK: begin
          ts_cnt  <= ts_cnt + CW'(1);
          per_cnt <= '0;
        end
        default: ;
      endcase

      if (stop && (state != IDLE)) stop_pend <= 1'b1;
    end
  end

endmodule
